mmu_access_controller: RTL and testbench
========================================

Name: mmu_access_controller

Overview:
- Sequences one load/store at a time between the decode stage's MMU fields and the external data memory.
- Reads the data register and the location (address) register from the register file.
- Issues a request/acknowledge memory transaction, then writes load data back to the register file.
- Holds off further operations while busy and flags illegal operations and memory timeouts.

Parameters:
- DATA_W, 32, width of register and memory data.
- ADDR_W, 32, width of the memory address.
- TIMEOUT, 16, maximum number of cycles mem_req stays high without mem_ack before abort. Must be >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  a decoded MMU op is present.
- op_ld  in  1  load flag.
- op_st  in  1  store flag.
- op_reg  in  4  data register index (load destination / store source).
- op_loca  in  4  register index holding the memory address.
- op_ready  out  1  op accepted this cycle if op_valid.
- rf_a_addr  out  4  register file read port A index (= op_reg).
- rf_a_data  in  DATA_W  port A data, combinational.
- rf_b_addr  out  4  register file read port B index (= op_loca).
- rf_b_data  in  DATA_W  port B data; low ADDR_W bits used.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  store data.
- mem_ack  in  1  memory completion, sampled only while mem_req=1.
- mem_rdata  in  DATA_W  load data, valid with mem_ack.
- wb_en  out  1  register file write strobe, 1 cycle.
- wb_addr  out  4  write index.
- wb_data  out  DATA_W  write data.
- busy  out  1  = ~op_ready.
- fault  out  1  1-cycle error pulse.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req, mem_we, wb_en and fault = 0; mem_addr, mem_wdata, wb_addr, wb_data and the timeout counter = 0. Reset mid-transaction abandons the op, with no writeback and no fault.
- State machine: IDLE, REQ, WB.
- op_ready = (state==IDLE), combinational. rf_a_addr and rf_b_addr are combinational pass-through of op_reg and op_loca in all states.
- Accept (IDLE, op_valid=1):
  - Exactly one of op_ld/op_st set: latch mem_addr=rf_b_data[ADDR_W-1:0], mem_wdata=rf_a_data, mem_we=op_st, wb_addr=op_reg. Next cycle: state REQ, mem_req=1, counter=0.
  - Both or neither set: op consumed, fault=1 next cycle, state stays IDLE, no mem_req.
- REQ, mem_ack=1: mem_req=0 next cycle.
  - Store: go to IDLE.
  - Load: wb_data=mem_rdata, wb_en=1 next cycle, state WB.
- REQ, mem_ack=0: counter increments. At counter==TIMEOUT-1 with no ack: mem_req=0, fault=1 next cycle, IDLE, no writeback. mem_ack arriving in that same cycle wins (normal completion, no fault).
- WB: wb_en high exactly one cycle, then IDLE. op_ready stays 0 during WB.
- mem_addr, mem_we and mem_wdata are held stable for the whole REQ phase.
- mem_ack while mem_req=0 is ignored.
- Best-case latency, accept to op_ready: store 2 cycles, load 3 cycles.
- All outputs except op_ready, busy, rf_a_addr and rf_b_addr are registered.

Decomposition:
- Package mmu_ctrl_pkg: state encoding (IDLE/REQ/WB), WB_REG code 2'b01 and WB_NONE code 2'b00 (same encoding as the decoder write field), default TIMEOUT constant.
- One natural sub-module: mmu_timeout_counter, with inputs clear, enable and rst_n and output expired at TIMEOUT-1.

Test Plan:
- Store, op_reg=3 (R3=0xDEADBEEF), op_loca=5 (R5=0x100), mem_ack on 2nd REQ cycle -> mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; no wb_en; op_ready back after ack.
- Load, op_reg=7, op_loca=2 (R2=0x40), ack in 1st REQ cycle with rdata=0x12345678 -> mem_we=0, then wb_en=1, wb_addr=7, wb_data=0x12345678 for exactly 1 cycle; 3-cycle turnaround.
- op_ld=op_st=1, then op_ld=op_st=0 -> fault pulse each time, mem_req never asserted, op_ready stays 1.
- Load with no mem_ack, TIMEOUT=16 -> mem_req high 16 cycles then drops, fault=1 for 1 cycle, no wb_en. Repeat with ack on the 16th cycle -> writeback, no fault.
- rst_n low during REQ -> mem_req, wb_en and fault = 0 immediately; after release op_ready=1, and a stale mem_ack produces nothing.
- Back-to-back ops with op_valid held -> second op accepted only in the cycle op_ready=1; no overlap of mem_req.

Source files
------------

// File: rtl/mmu_ctrl_pkg.sv
// Shared definitions for the MMU access controller.
//   mmu_state_e     : controller state encoding (IDLE / REQ / WB)
//   WB_NONE, WB_REG : writeback selector codes, same encoding as the decoder write field
//   TIMEOUT_DEFAULT : default request timeout in cycles
//   op_is_legal()   : a decoded op is legal when exactly one of load/store is set
package mmu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WB   = 2'b10
    } mmu_state_e;

    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_REG  = 2'b01;

    localparam int TIMEOUT_DEFAULT = 16;

    function automatic logic op_is_legal(input logic ld, input logic st);
        return ld ^ st;
    endfunction

endpackage

// File: rtl/mmu_timeout_counter.sv
// Request timeout timer for the MMU access controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : start a new timing window (TIMEOUT-1 cycles remaining)
//   enable     : one more REQ cycle elapsed without an acknowledge
//   expired    : the current cycle is the TIMEOUT-th cycle of the window
// Implemented as a down-counter with a terminal-count compare at zero. The
// reset value of zero reads as expired, which is harmless because every
// request window starts with a clear.
module mmu_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = CNT_LOAD;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/mmu_access_controller.sv
// Sequences one load/store at a time between the decoded MMU fields and the
// external data memory, with writeback of load data to the register file.
//   op_*        : decoded op handshake (op_ready = accepted this cycle)
//   rf_a_*      : register file port A, data register (store source)
//   rf_b_*      : register file port B, address register
//   mem_*       : request/acknowledge memory interface
//   wb_*        : one-cycle register file write strobe, index and data
//   busy, fault : ~op_ready, one-cycle error pulse (illegal op or timeout)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for an op; illegal ops are consumed here with a fault
// ST_REQ  | mem_req high, waiting for mem_ack or the timeout
// ST_WB   | load data presented on wb_* for exactly one cycle
module mmu_access_controller
    import mmu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic              op_ld,
    input  logic              op_st,
    input  logic [3:0]        op_reg,
    input  logic [3:0]        op_loca,
    output logic              op_ready,
    output logic [3:0]        rf_a_addr,
    input  logic [DATA_W-1:0] rf_a_data,
    output logic [3:0]        rf_b_addr,
    input  logic [DATA_W-1:0] rf_b_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    output logic              fault
);

    mmu_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic              wb_en_q, wb_en_d;
    logic [3:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              fault_q, fault_d;

    logic tmr_clear, tmr_en, tmr_expired;

    mmu_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_sel_d    = wb_sel_q;
        wb_en_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        fault_d     = 1'b0;
        tmr_clear   = 1'b0;
        tmr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    if (op_is_legal(op_ld, op_st)) begin
                        mem_addr_d  = rf_b_data[ADDR_W-1:0];
                        mem_wdata_d = rf_a_data;
                        mem_we_d    = op_st;
                        wb_addr_d   = op_reg;
                        wb_sel_d    = op_ld ? WB_REG : WB_NONE;
                        mem_req_d   = 1'b1;
                        tmr_clear   = 1'b1;
                        state_d     = ST_REQ;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // An acknowledge in the final timeout cycle still completes normally.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (wb_sel_q == WB_REG) begin
                        wb_data_d = mem_rdata;
                        wb_en_d   = 1'b1;
                        state_d   = ST_WB;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmr_expired) begin
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_sel_q    <= WB_NONE;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_sel_q    <= wb_sel_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            fault_q     <= fault_d;
        end
    end

    assign op_ready  = (state_q == ST_IDLE);
    assign busy      = ~op_ready;
    assign rf_a_addr = op_reg;
    assign rf_b_addr = op_loca;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_en     = wb_en_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_mmu_access_controller.sv
// Scoreboard bench for mmu_access_controller: a driver issues ops and pushes the
// expected memory request / writeback / fault events; a memory responder
// acknowledges after a planned delay; a monitor pops and compares events.
module tb_mmu_access_controller;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    localparam int EV_REQ   = 0;
    localparam int EV_WB    = 1;
    localparam int EV_FAULT = 2;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
    } ev_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } plan_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              op_valid, op_ld, op_st;
    logic [3:0]        op_reg, op_loca;
    logic              op_ready;
    logic [3:0]        rf_a_addr, rf_b_addr;
    logic [DATA_W-1:0] rf_a_data, rf_b_data;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              wb_en;
    logic [3:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              busy, fault;

    logic [31:0] regs [16];
    ev_t         exp_q [$];
    plan_t       plan_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          stray_en = 1'b0;

    assign rf_a_data = regs[rf_a_addr];
    assign rf_b_data = regs[rf_b_addr];

    always #5 clk = ~clk;

    mmu_access_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ld     (op_ld),
        .op_st     (op_st),
        .op_reg    (op_reg),
        .op_loca   (op_loca),
        .op_ready  (op_ready),
        .rf_a_addr (rf_a_addr),
        .rf_a_data (rf_a_data),
        .rf_b_addr (rf_b_addr),
        .rf_b_data (rf_b_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .busy      (busy),
        .fault     (fault)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic bit pop_exp(input string who, output ev_t e);
        e = '{kind: -1, we: 1'b0, addr: 32'd0, data: 32'd0, len: 0};
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected %s: no event outstanding (t=%0t)", who, $time);
            return 1'b0;
        end
        e = exp_q.pop_front();
        return 1'b1;
    endfunction

    // Memory responder: acks on REQ cycle index 'delay' (0 = first cycle).
    int    r_cyc;
    bit    r_in = 1'b0;
    plan_t r_cur;
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (!r_in) begin
                r_in  = 1'b1;
                r_cyc = 0;
                if (plan_q.size() != 0) r_cur = plan_q.pop_front();
                else r_cur = '{delay: 1000, rdata: 32'd0};
            end else begin
                r_cyc++;
            end
            mem_ack   = (r_cyc == r_cur.delay);
            mem_rdata = mem_ack ? r_cur.rdata : $urandom;
        end else begin
            r_in      = 1'b0;
            mem_ack   = stray_en | ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    end

    // Monitor / scoreboard.
    bit  m_in = 1'b0;
    int  m_len;
    ev_t m_cur;
    always @(negedge clk) begin
        ev_t e;
        if (rst_n !== 1'b1) begin
            m_in  = 1'b0;
            m_len = 0;
        end else begin
            check("busy_vs_ready", busy, !op_ready);
            if (fault) begin
                if (pop_exp("fault", e)) check("fault_event_kind", e.kind, EV_FAULT);
            end
            if (wb_en) begin
                if (pop_exp("wb_en", e)) begin
                    check("wb_event_kind", e.kind, EV_WB);
                    check("wb_addr", wb_addr, e.addr);
                    check("wb_data", wb_data, e.data);
                end
            end
            if (mem_req && !m_in) begin
                m_in  = 1'b1;
                m_len = 1;
                if (pop_exp("mem_req", e)) begin
                    m_cur = e;
                    check("req_event_kind", e.kind, EV_REQ);
                    check("mem_we", mem_we, e.we);
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wdata", mem_wdata, e.data);
                end else begin
                    m_cur = '{kind: EV_REQ, we: mem_we, addr: mem_addr, data: mem_wdata, len: -1};
                end
            end else if (mem_req && m_in) begin
                m_len++;
                check("mem_we_stable", mem_we, m_cur.we);
                check("mem_addr_stable", mem_addr, m_cur.addr);
                check("mem_wdata_stable", mem_wdata, m_cur.data);
            end else if (!mem_req && m_in) begin
                m_in = 1'b0;
                check("mem_req_cycles", m_len, m_cur.len);
            end
        end
    end

    // Drive one op; returns at the negedge after the accepting edge with op_valid low.
    task automatic issue_op(input logic ld, input logic st, input logic [3:0] r,
                            input logic [3:0] loca, input int delay, input logic [31:0] rdata);
        int  waited = 0;
        ev_t e;
        op_valid = 1'b1;
        op_ld    = ld;
        op_st    = st;
        op_reg   = r;
        op_loca  = loca;
        while (!op_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_accept_timeout: op_ready still 0 after %0d cycles", waited);
        end else if (ld ^ st) begin
            e = '{kind: EV_REQ, we: st, addr: regs[loca], data: regs[r],
                  len: (delay < TIMEOUT) ? delay + 1 : TIMEOUT};
            exp_q.push_back(e);
            plan_q.push_back('{delay: delay, rdata: rdata});
            if (delay >= TIMEOUT)
                exp_q.push_back('{kind: EV_FAULT, we: 1'b0, addr: 32'd0, data: 32'd0, len: 0});
            else if (ld)
                exp_q.push_back('{kind: EV_WB, we: 1'b0, addr: {28'd0, r}, data: rdata, len: 0});
        end else begin
            exp_q.push_back('{kind: EV_FAULT, we: 1'b0, addr: 32'd0, data: 32'd0, len: 0});
        end
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until op_ready is seen again.
    task automatic wait_ready(output int cyc);
        cyc = 1;
        while (!op_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regs[3] = 32'hDEADBEEF;
        regs[5] = 32'h0000_0100;
        regs[2] = 32'h0000_0040;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_ld    = 1'b0;
        op_st    = 1'b0;
        op_reg   = 4'd0;
        op_loca  = 4'd0;
        mem_ack  = 1'b0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_fault", fault, 0);
        check("rst_op_ready", op_ready, 1);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Store R3 -> [R5], ack on 2nd REQ cycle.
        issue_op(1'b0, 1'b1, 4'd3, 4'd5, 1, 32'd0);
        wait_ready(lat);
        check("store_ack2_latency", lat, 3);
        // Store with immediate ack: best-case 2 cycles.
        issue_op(1'b0, 1'b1, 4'd3, 4'd5, 0, 32'd0);
        wait_ready(lat);
        check("store_best_latency", lat, 2);
        // Load R7 <- [R2], ack in 1st REQ cycle: best-case 3 cycles.
        issue_op(1'b1, 1'b0, 4'd7, 4'd2, 0, 32'h12345678);
        wait_ready(lat);
        check("load_best_latency", lat, 3);

        // Illegal ops: fault pulse each, no request, stays ready.
        issue_op(1'b1, 1'b1, 4'd1, 4'd2, 0, 32'd0);
        check("illegal_both_ready", op_ready, 1);
        issue_op(1'b0, 1'b0, 4'd1, 4'd2, 0, 32'd0);
        check("illegal_none_ready", op_ready, 1);
        repeat (2) @(negedge clk);

        // Timeout: no ack ever, then ack on the very last REQ cycle.
        issue_op(1'b1, 1'b0, 4'd7, 4'd2, TIMEOUT + 5, 32'h0);
        wait_ready(lat);
        check("timeout_latency", lat, TIMEOUT + 1);
        issue_op(1'b1, 1'b0, 4'd7, 4'd2, TIMEOUT - 1, 32'hCAFEF00D);
        wait_ready(lat);
        check("last_cycle_ack_latency", lat, TIMEOUT + 2);

        // Reset in the middle of a request.
        issue_op(1'b1, 1'b0, 4'd4, 4'd6, TIMEOUT + 5, 32'h0);
        repeat (3) @(negedge clk);
        #2;
        rst_n    = 1'b0;
        stray_en = 1'b1;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_wb_en", wb_en, 0);
        check("midrst_fault", fault, 0);
        check("midrst_op_ready", op_ready, 1);
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_op_ready", op_ready, 1);
        end
        stray_en = 1'b0;

        // Back-to-back ops with op_valid held, then randomized traffic.
        issue_op(1'b0, 1'b1, 4'd9, 4'd10, 2, 32'h0);
        issue_op(1'b1, 1'b0, 4'd11, 4'd12, 1, 32'h55AA55AA);
        issue_op(1'b0, 1'b1, 4'd13, 4'd14, 0, 32'h0);
        for (int n = 0; n < 300; n++) begin
            logic ld, st;
            int   d;
            int   sel = $urandom_range(0, 19);
            if (sel < 2) begin
                ld = sel[0];
                st = sel[0];
            end else begin
                ld = $urandom_range(0, 1);
                st = !ld;
            end
            case ($urandom_range(0, 9))
                0:       d = TIMEOUT - 1;
                1:       d = TIMEOUT;
                2:       d = TIMEOUT - 2;
                default: d = $urandom_range(0, 4);
            endcase
            issue_op(ld, st, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), d, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (TIMEOUT + 10) @(negedge clk);
        check("events_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
